// File: rtl/ext_mem_slave.sv
// ext_mem_slave: latency-programmable byte-wide memory responder for the
// dual-channel master bus of the HLS `main` accelerator. Each channel runs its
// own IDLE/WAIT/DONE sequencer; the shared byte array is preloadable, has a
// combinational dump port and is deliberately left out of reset.

// Per-channel request sequencer: latches one transaction, counts the delay,
// then presents a one-cycle completion pulse (plus read data for reads).
module ext_mem_chan #(
  parameter int RD_DLY = 2,
  parameter int WR_DLY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_oe,
  input  logic       i_we,
  input  logic       i_inr,
  input  logic [7:0] i_rbyte,
  output logic       o_wr,
  output logic       o_rdy,
  output logic [7:0] o_rdata,
  output logic       o_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_is_rd, w_is_rd_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_err, w_err_set;
  logic       r_rdy;
  logic [7:0] r_rdata;
  logic       w_start_wr;

  // Next-state, counter and latch selection; requests only count in IDLE
  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_rd_nxt = r_is_rd;
    w_data_nxt  = r_data;
    w_err_set   = 1'b0;
    w_start_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_inr) begin
          if (i_oe && i_we) begin
            w_err_set = 1'b1;
          end else if (i_oe) begin
            w_is_rd_nxt = 1'b1;
            w_data_nxt  = i_rbyte;
            w_cnt_nxt   = 4'(RD_DLY - 1);
            w_nxt       = (RD_DLY == 1) ? S_DONE : S_WAIT;
          end else if (i_we) begin
            w_start_wr  = 1'b1;
            w_is_rd_nxt = 1'b0;
            w_cnt_nxt   = 4'(WR_DLY - 1);
            w_nxt       = (WR_DLY == 1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State, counter, latched request and registered completion outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_rd <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_rd <= w_is_rd_nxt;
      r_data  <= w_data_nxt;
      r_err   <= r_err | w_err_set;
      r_rdy   <= (w_nxt == S_DONE);
      r_rdata <= (w_nxt == S_DONE && w_is_rd_nxt) ? w_data_nxt : 8'h00;
    end
  end

  assign o_wr    = w_start_wr;
  assign o_rdy   = r_rdy;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;
endmodule

module ext_mem_slave #(
  parameter int MEMSIZE     = 32,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 7,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Mout_oe_ram,
  input  logic [1:0]          Mout_we_ram,
  input  logic [2*ADDR_W-1:0] Mout_addr_ram,
  input  logic [15:0]         Mout_Wdata_ram,
  input  logic [7:0]          Mout_data_ram_size,
  output logic [15:0]         M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  input  logic                load_we,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [7:0]          load_data,
  input  logic [ADDR_W-1:0]   dump_addr,
  output logic [7:0]          dump_data,
  output logic [1:0]          err
);
  localparam int NCH   = 2;
  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [7:0] r_mem [MEMSIZE];

  logic [NCH-1:0]            w_inr, w_wr, w_rdy, w_err;
  logic [NCH-1:0][IDX_W-1:0] w_idx;
  logic [NCH-1:0][7:0]       w_mask, w_rbyte, w_rdata, w_wdata;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [31:0] w_a;
    logic [3:0]  w_sz;
    assign w_a          = 32'(Mout_addr_ram[ch*ADDR_W +: ADDR_W]);
    assign w_sz         = Mout_data_ram_size[ch*4 +: 4];
    assign w_inr[ch]    = (w_a >= 32'(BASE_ADDR)) && (w_a < 32'(BASE_ADDR + MEMSIZE));
    assign w_idx[ch]    = IDX_W'(w_a - 32'(BASE_ADDR));
    // Widths of 8 or more select the whole byte; width 0 writes nothing
    assign w_mask[ch]   = (w_sz >= 4'd8) ? 8'hFF : 8'((9'd1 << w_sz) - 9'd1);
    assign w_wdata[ch]  = Mout_Wdata_ram[ch*8 +: 8];
    assign w_rbyte[ch]  = r_mem[w_idx[ch]];

    ext_mem_chan #(.RD_DLY(READ_DELAY), .WR_DLY(WRITE_DELAY)) u_chan (
      .clock   (clock),
      .reset   (reset),
      .i_oe    (Mout_oe_ram[ch]),
      .i_we    (Mout_we_ram[ch]),
      .i_inr   (w_inr[ch]),
      .i_rbyte (w_rbyte[ch]),
      .o_wr    (w_wr[ch]),
      .o_rdy   (w_rdy[ch]),
      .o_rdata (w_rdata[ch]),
      .o_err   (w_err[ch])
    );
  end

  // Storage: preload first, then bus writes so channel 1 has the last word
  always_ff @(posedge clock) begin
    if (load_we && (32'(load_addr) < 32'(MEMSIZE)))
      r_mem[load_addr[IDX_W-1:0]] <= load_data;
    for (int ch = 0; ch < NCH; ch++) begin
      if (w_wr[ch])
        r_mem[w_idx[ch]] <= (w_wdata[ch] & w_mask[ch]) | (r_mem[w_idx[ch]] & ~w_mask[ch]);
    end
  end

  // Combinational readback; indices past the array read as zero
  always_comb begin
    dump_data = 8'h00;
    if (32'(dump_addr) < 32'(MEMSIZE)) dump_data = r_mem[dump_addr[IDX_W-1:0]];
  end

  assign M_Rdata_ram = w_rdata;
  assign M_DataRdy   = w_rdy;
  assign err         = w_err;
endmodule
